// File: rtl/sram_arb_pkg.sv
// Shared types and the rotating-priority pick used by the SRAM request arbiter.
// Pure combinational helpers, no state and no flow control.
package sram_arb_pkg;

   localparam int unsigned MaxReq     = 32;
   localparam int unsigned MaxIdxW    = $clog2(MaxReq);
   localparam int unsigned NumReqDflt = 2;

   typedef logic [$clog2(NumReqDflt)-1:0] req_idx_t;

   // Walk offsets from high to low so the smallest offset from ptr wins.
   function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                           input int unsigned       ptr,
                                           input int unsigned       n);
      int unsigned idx;
      rr_pick = 0;
      for (int unsigned k = n; k > 0; k--) begin
         idx = ptr + k - 1;
         if (idx >= n) idx = idx - n;
         if (req[idx[MaxIdxW-1:0]]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Generic synchronous FIFO with a shift-register store; head always sits in slot 0.
// Zero-cycle read of the head; optional pass-through when empty (Pass=1).
// Back-pressure: wready_o drops when the registered count reaches Depth.
module prim_fifo_sync #(
   parameter int unsigned Width  = 16,
   parameter bit          Pass   = 1'b1,
   parameter int unsigned Depth  = 4,
   localparam int unsigned DepthW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             wvalid_i,
   output logic             wready_o,
   input  logic [Width-1:0] wdata_i,
   output logic             rvalid_o,
   input  logic             rready_i,
   output logic [Width-1:0] rdata_o
);

   logic [DepthW-1:0]      cnt_q, cnt_d;
   logic [Depth*Width-1:0] mem_q, mem_d;
   logic                   empty, pass_thru, push, pop;
   int                     wr_pos;

   assign empty     = (cnt_q == '0);
   assign pass_thru = Pass && empty && wvalid_i;
   assign wready_o  = (cnt_q != DepthW'(Depth));
   assign rvalid_o  = !empty || pass_thru;
   assign rdata_o   = (Pass && empty) ? wdata_i : mem_q[Width-1:0];
   assign push      = wvalid_i && wready_o && !(pass_thru && rready_i);
   assign pop       = !empty && rready_i;
   assign wr_pos    = int'(cnt_q) - int'(pop);

   always_comb begin
      mem_d = mem_q;
      if (pop) mem_d = mem_q >> Width;
      if (push) mem_d[wr_pos*Width +: Width] = wdata_i;
      cnt_d = cnt_q + DepthW'(push) - DepthW'(pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         mem_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/sram_req_arb.sv
// Round-robin arbiter sharing one SRAM port; tags reads so responses return to their owner.
// Zero-cycle request and response paths; only ptr and the tag FIFO are registered.
// Stalls every requester while the tag FIFO is full; SRAM_ARB_FIXED_PRIO_EN selects fixed priority.
module sram_req_arb
   import sram_arb_pkg::*;
#(
   parameter int unsigned NumReq      = 2,
   parameter int unsigned SramAw      = 12,
   parameter int unsigned SramDw      = 32,
   parameter int unsigned Outstanding = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NumReq-1:0]        req_i,
   output logic [NumReq-1:0]        gnt_o,
   input  logic [NumReq-1:0]        we_i,
   input  logic [NumReq*SramAw-1:0] addr_i,
   input  logic [NumReq*SramDw-1:0] wdata_i,
   input  logic [NumReq*SramDw-1:0] wmask_i,
   output logic [SramDw-1:0]        rdata_o,
   output logic [NumReq-1:0]        rvalid_o,
   output logic [NumReq*2-1:0]      rerror_o,
   output logic                     req_o,
   output logic                     we_o,
   output logic [SramAw-1:0]        addr_o,
   output logic [SramDw-1:0]        wdata_o,
   output logic [SramDw-1:0]        wmask_o,
   input  logic                     gnt_i,
   input  logic [SramDw-1:0]        rdata_i,
   input  logic                     rvalid_i,
   input  logic [1:0]               rerror_i,
   output logic                     rsp_err_o
);

   localparam int unsigned IdxW = $clog2(NumReq);

   logic [MaxReq-1:0] req_ext;
   logic [IdxW-1:0]   win, ptr, tag;
   logic              blk, hs, rd_hs, tag_vld, tag_rdy;

   always_comb begin
      req_ext              = '0;
      req_ext[NumReq-1:0]  = req_i;
   end

   assign win = IdxW'(rr_pick(req_ext, 32'(ptr), NumReq));

`ifdef SRAM_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   logic [IdxW-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (hs) ptr_d = (32'(win) == NumReq - 1) ? '0 : win + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
`endif

   // Full is taken from the registered count, so a same-cycle pop never unblocks.
   assign blk   = ~tag_rdy;
   assign req_o = (|req_i) & ~blk;
   assign hs    = req_o & gnt_i;
   assign rd_hs = hs & ~we_o;

   always_comb begin
      we_o    = 1'b0;
      addr_o  = '0;
      wdata_o = '0;
      wmask_o = '0;
      gnt_o   = '0;
      if (req_o) begin
         we_o       = we_i[win];
         addr_o     = addr_i[win*SramAw +: SramAw];
         wdata_o    = wdata_i[win*SramDw +: SramDw];
         wmask_o    = wmask_i[win*SramDw +: SramDw];
         gnt_o[win] = gnt_i;
      end
   end

   prim_fifo_sync #(
      .Width (IdxW),
      .Pass  (1'b0),
      .Depth (Outstanding)
   ) u_tag_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (1'b0),
      .wvalid_i (rd_hs),
      .wready_o (tag_rdy),
      .wdata_i  (win),
      .rvalid_o (tag_vld),
      .rready_i (rvalid_i),
      .rdata_o  (tag)
   );

   assign rdata_o   = rdata_i;
   assign rsp_err_o = rvalid_i & ~tag_vld;

   always_comb begin
      rvalid_o = '0;
      rerror_o = '0;
      if (rvalid_i && tag_vld) begin
         rvalid_o[tag]       = 1'b1;
         rerror_o[tag*2 +: 2] = rerror_i;
      end
   end

endmodule
